// File: rtl/cosim_reset_responder.sv
// DUT-side end of the cosim reset handshake.
// A level reset request from the testbench driver is synchronized, the core
// reset is held for a fixed number of cycles, and the request is then
// acknowledged with a four-phase req/ack handshake. While the core runs,
// a saturating cycle counter is compared against a driver-supplied limit.
module cosim_reset_responder #(
  parameter int unsigned SYNC_STAGES = 2,   // 2..4
  parameter int unsigned HOLD_CYCLES = 4,   // 1..255
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rst_req,
  output logic                 rst_ack,
  output logic                 core_rst,
  input  logic [CNT_WIDTH-1:0] run_limit,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 limit_reached
);

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam logic [7:0]           HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;

  state_e                 state_q, state_d;
  logic [7:0]             hold_cnt_q, hold_cnt_d;
  logic [CNT_WIDTH-1:0]   cycle_count_q, cycle_count_d;
  logic                   limit_reached_q, limit_reached_d;
  logic                   core_rst_q, core_rst_d;
  logic                   rst_ack_q, rst_ack_d;

  // Synchronizer shift: new sample enters bit 0, req_s is the oldest bit.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rst_req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Next-state, hold/run counters, sticky limit flag and registered outputs.
  always_comb begin
    state_d         = state_q;
    hold_cnt_d      = hold_cnt_q;
    cycle_count_d   = cycle_count_q;
    limit_reached_d = limit_reached_q;

    case (state_q)
      ST_POR: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          // A request still pending after power-on skips straight to ACK.
          state_d = req_s ? ST_ACK : ST_RUN;
        end
      end
      ST_HOLD: begin
        // The hold always runs to completion, even if req_s drops meanwhile.
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req_s) begin
          // A new request wins over counting, including at saturation.
          state_d         = ST_HOLD;
          hold_cnt_d      = '0;
          cycle_count_d   = '0;
          limit_reached_d = 1'b0;
        end else begin
          if (cycle_count_q != CNT_MAX) begin
            cycle_count_d = cycle_count_q + CNT_ONE;
          end
          // Compare against the next count so the flag rises on the same
          // edge the counter reaches the limit; a zero limit means unlimited.
          if ((run_limit != '0) && (cycle_count_d >= run_limit)) begin
            limit_reached_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_POR;
      end
    endcase

    // Outputs are registered alongside the state so they change on the same edge.
    core_rst_d = (state_d != ST_RUN);
    rst_ack_d  = (state_d == ST_ACK);
  end

  // Synchronizer flops, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // State, counters and output registers; rst_n forces power-on values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_POR;
      hold_cnt_q      <= '0;
      cycle_count_q   <= '0;
      limit_reached_q <= 1'b0;
      core_rst_q      <= 1'b1;
      rst_ack_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_cnt_q      <= hold_cnt_d;
      cycle_count_q   <= cycle_count_d;
      limit_reached_q <= limit_reached_d;
      core_rst_q      <= core_rst_d;
      rst_ack_q       <= rst_ack_d;
    end
  end

  assign core_rst      = core_rst_q;
  assign rst_ack       = rst_ack_q;
  assign cycle_count   = cycle_count_q;
  assign limit_reached = limit_reached_q;

endmodule

// File: tb/tb_cosim_reset_responder.sv
// Directed bench for cosim_reset_responder: expected per-edge outputs are
// queued as stimulus is applied and popped/compared after each clock edge.
module tb_cosim_reset_responder;

  logic        clk = 1'b0;

  // Main instance: defaults (SYNC_STAGES=2, HOLD_CYCLES=4, CNT_WIDTH=32).
  logic        rst_n, rst_req;
  logic [31:0] run_limit;
  logic        rst_ack, core_rst, limit_reached;
  logic [31:0] cycle_count;

  // Narrow-counter instance for the saturation case.
  logic        rst2_n, rst_req2;
  logic [3:0]  run_limit2;
  logic        rst_ack2, core_rst2, limit_reached2;
  logic [3:0]  cycle_count2;

  typedef struct {
    string       tag;
    bit          dut;
    logic        core;
    logic        ack;
    logic        lim;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cosim_reset_responder #(
    .SYNC_STAGES(2), .HOLD_CYCLES(4), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rst_req(rst_req), .rst_ack(rst_ack),
    .core_rst(core_rst), .run_limit(run_limit), .cycle_count(cycle_count),
    .limit_reached(limit_reached)
  );

  cosim_reset_responder #(
    .SYNC_STAGES(2), .HOLD_CYCLES(4), .CNT_WIDTH(4)
  ) dut_narrow (
    .clk(clk), .rst_n(rst2_n), .rst_req(rst_req2), .rst_ack(rst_ack2),
    .core_rst(core_rst2), .run_limit(run_limit2), .cycle_count(cycle_count2),
    .limit_reached(limit_reached2)
  );

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input bit d, input logic core,
                      input logic ack, input logic lim, input logic [31:0] cnt);
    exp_t e;
    e.tag  = tag;
    e.dut  = d;
    e.core = core;
    e.ack  = ack;
    e.lim  = lim;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.dut == 1'b0) begin
        chk(e.tag, "core_rst",      {31'd0, core_rst},      {31'd0, e.core});
        chk(e.tag, "rst_ack",       {31'd0, rst_ack},       {31'd0, e.ack});
        chk(e.tag, "limit_reached", {31'd0, limit_reached}, {31'd0, e.lim});
        chk(e.tag, "cycle_count",   cycle_count,            e.cnt);
      end else begin
        chk(e.tag, "core_rst",      {31'd0, core_rst2},      {31'd0, e.core});
        chk(e.tag, "rst_ack",       {31'd0, rst_ack2},       {31'd0, e.ack});
        chk(e.tag, "limit_reached", {31'd0, limit_reached2}, {31'd0, e.lim});
        chk(e.tag, "cycle_count",   {28'd0, cycle_count2},   e.cnt);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue n expected cycles (count fixed or incrementing), then clock and compare each.
  task automatic cyc(input string tag, input bit d, input int n, input logic core,
                     input logic ack, input logic lim, input int cnt0, input bit inc);
    for (int i = 0; i < n; i++) begin
      push(tag, d, core, ack, lim, inc ? 32'(cnt0 + i) : 32'(cnt0));
    end
    for (int i = 0; i < n; i++) begin
      tick();
      compare_head();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    rst_req    = 1'b0;
    run_limit  = '0;
    rst2_n     = 1'b0;
    rst_req2   = 1'b0;
    run_limit2 = '0;
    repeat (2) tick();

    // Reset state of both instances.
    push("reset_state", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0); compare_head();
    push("reset_state2", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0); compare_head();

    // 1: power-on hold of exactly four edges, then counting from 0.
    rst_n = 1'b1;
    cyc("t1_por",     1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("t1_release", 1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("t1_count",   1'b0, 5, 1'b0, 1'b0, 1'b0, 1, 1'b1);   // edges 5..9

    // 2: request sampled at edge 10, dropped sampled at edge 20.
    rst_req = 1'b1;
    cyc("t2_sync",     1'b0, 2, 1'b0, 1'b0, 1'b0, 6, 1'b1);  // edges 10,11
    cyc("t2_hold",     1'b0, 4, 1'b1, 1'b0, 1'b0, 0, 1'b0);  // edges 12..15
    cyc("t2_ack",      1'b0, 4, 1'b1, 1'b1, 1'b0, 0, 1'b0);  // edges 16..19
    rst_req = 1'b0;
    cyc("t2_ack_hold", 1'b0, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0);  // edges 20,21
    cyc("t2_release",  1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);  // edge 22

    // 3: limit of 100 is sticky, survives a limit change, cleared by handshake.
    run_limit = 32'd100;
    cyc("t3_below",  1'b0, 99, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc("t3_hit",    1'b0, 1,  1'b0, 1'b0, 1'b1, 100, 1'b0);
    cyc("t3_sticky", 1'b0, 5,  1'b0, 1'b0, 1'b1, 101, 1'b1);
    run_limit = 32'd500;
    cyc("t3_newlim", 1'b0, 5,  1'b0, 1'b0, 1'b1, 106, 1'b1);
    rst_req = 1'b1;
    cyc("t3_sync",   1'b0, 2,  1'b0, 1'b0, 1'b1, 111, 1'b1);
    cyc("t3_hold",   1'b0, 4,  1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("t3_ack",    1'b0, 1,  1'b1, 1'b1, 1'b0, 0, 1'b0);
    rst_req = 1'b0;
    cyc("t3_ack_hold", 1'b0, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cyc("t3_run",      1'b0, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // 5: asynchronous reset in HOLD (hold_cnt=2) and in ACK, request kept high.
    rst_req = 1'b1;
    cyc("t5_sync", 1'b0, 2, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    cyc("t5_hold", 1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    push("t5_async_hold", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0); compare_head();
    tick();
    rst_n = 1'b1;
    cyc("t5_por",     1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("t5_por_ack", 1'b0, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    push("t5_async_ack", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0); compare_head();
    tick();
    rst_n = 1'b1;
    cyc("t5_por2",     1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("t5_por2_ack", 1'b0, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    rst_req = 1'b0;
    cyc("t5_ack_hold", 1'b0, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cyc("t5_run",      1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // 6: three-cycle request pulse gives full hold and a one-cycle ACK.
    rst_req = 1'b1;
    cyc("t6_sync",  1'b0, 2, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc("t6_hold0", 1'b0, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    rst_req = 1'b0;
    cyc("t6_hold",  1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("t6_ack",   1'b0, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    cyc("t6_run",   1'b0, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // 4: 4-bit counter, unlimited: saturates at 15, flag never sets,
    //    and a request while saturated still enters HOLD.
    rst2_n = 1'b1;
    cyc("t4_por",     1'b1, 3,  1'b1, 1'b0, 1'b0, 0, 1'b0);
    cyc("t4_release", 1'b1, 1,  1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc("t4_count",   1'b1, 15, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    cyc("t4_sat",     1'b1, 25, 1'b0, 1'b0, 1'b0, 15, 1'b0);
    rst_req2 = 1'b1;
    cyc("t4_sat_req", 1'b1, 2,  1'b0, 1'b0, 1'b0, 15, 1'b0);
    cyc("t4_hold",    1'b1, 1,  1'b1, 1'b0, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
